pmem_responder: RTL
===================

// Module: pmem_responder
// PURPOSE
//  Responder (memory) end of the pmem line interface. Cache-side initiators and the
//  write-back eviction path drive read/write/address/wdata into this block.
//  It accepts one line request at a time and waits a fixed LATENCY.
//  It then pulses resp for one cycle, returning rdata on reads and committing wdata on writes.
//  It backs a small on-chip line store, used as the synthesizable pmem for integration runs.
// PARAMETERS
//  LATENCY  4   cycles from acceptance to resp; legal range 1..15
//  DEPTH    16  lines in the store; power of 2; index = address[4 +: $clog2(DEPTH)]
// PORTS
//  clk           in   1    single clock, all state on posedge
//  reset         in   1    synchronous, active-high
//  read          in   1    line read request, held until resp
//  write         in   1    line write request, held until resp
//  address       in   16   lc3b_pmem_addr; bits [3:0] ignored (line aligned)
//  wdata         in   128  lc3b_pmem_line write data
//  resp          out  1    one-cycle completion pulse
//  rdata         out  128  read line; valid only while resp=1 for a read
//  busy          out  1    transaction accepted and not yet responded
//  protocol_err  out  1    sticky; read&write seen together
//  rd_count      out  16   saturating count of completed reads
//  wr_count      out  16   saturating count of completed writes
// BEHAVIOUR
//  Reset (sync, any state, including mid-transaction):
//   - state=IDLE; resp=0, busy=0, rdata=0, protocol_err=0
//   - counters=0; all DEPTH store lines cleared to 0
//   - an in-flight write is dropped, not committed
//  States: IDLE, BUSY, RESP.
//  IDLE:
//   - if read|write: latch address, wdata and op (write wins if both are set)
//   - load cnt=LATENCY-1; go to RESP if LATENCY==1, else go to BUSY
//  BUSY:
//   - busy=1; cnt decrements each cycle
//   - at cnt==1, go to RESP
//   - if read and write both drop, it is an abort: back to IDLE, nothing committed, no resp
//  RESP (exactly one cycle):
//   - resp=1, busy=1
//   - read: rdata = store[idx]
//   - write: store[idx] <= latched wdata at the end of this cycle; rdata=0
//   - the op's counter increments and saturates at 16'hFFFF
//   - next state is always IDLE
//  Latency: request first high in cycle 0 -> resp high in cycle LATENCY.
//  Back-to-back: the initiator must drop its request in the cycle after resp. A request
//   still high in IDLE starts a new transaction (no dead cycle required).
//  address/wdata/op changes after acceptance are ignored; the latched copy is used.
//  read&write both high in any cycle: protocol_err <= 1 (sticky until reset); write proceeds.
//  Read in the cycle after a write RESP to the same line returns the new data (no bypass needed).
//  Address aliasing: bits above the index are ignored; DEPTH lines wrap around.
// STRUCTURE
//  - lc3b_types already supplies lc3b_pmem_line and lc3b_pmem_addr; use them.
//  - Add to lc3b_types: pmem_resp_state_t enum {IDLE,BUSY,RESP} for shared bench decode.
//  - Address/wdata latches reuse the existing register module (flush tied 0).
//  - One sub-module: pmem_line_array (DEPTH x 128, sync write, async read, sync clear).
//  - FSM and counters stay local.
// TESTING
//  1 reset, then read 0x1230 -> resp in cycle 4, rdata=0, rd_count=1, busy=1 in cycles 1..4
//  2 write 0x1230 with 128'hDEAD..BEEF, then read 0x123E -> read returns DEAD..BEEF; wr_count=1
//  3 write 0x0040, address changed to 0x0080 in cycle 2 -> line 4 updated, line 8 still 0
//  4 read dropped in cycle 2 of BUSY -> no resp, counters unchanged; a new read is
//    accepted cleanly next cycle
//  5 read&write high with wdata=128'h1 at 0x0010 -> write done, protocol_err=1 until reset
//  6 reset asserted in cycle 2 of a write -> resp never pulses; line reads back 0;
//    LATENCY=1 variant: resp in cycle 1

Source files
------------

// File: rtl/pmem_responder_pkg.sv
// rtl/pmem_responder_pkg.sv - shared pmem line types, responder state encoding and helpers
package pmem_responder_pkg;

    typedef logic [127:0] lc3b_pmem_line;
    typedef logic [15:0]  lc3b_pmem_addr;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } pmem_resp_state_t;

    // Lines are 16 bytes; the byte offset within a line is never used.
    localparam int PMEM_LINE_OFFSET = 4;

    // Completion counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pmem_responder_if.sv
// rtl/pmem_responder_if.sv - pmem line request/response bus between initiator and responder
interface pmem_responder_if;
    import pmem_responder_pkg::*;

    logic          read;
    logic          write;
    lc3b_pmem_addr address;
    lc3b_pmem_line wdata;
    logic          resp;
    lc3b_pmem_line rdata;

    modport master (
        output read,
        output write,
        output address,
        output wdata,
        input  resp,
        input  rdata
    );

    modport slave (
        input  read,
        input  write,
        input  address,
        input  wdata,
        output resp,
        output rdata
    );

endinterface

// File: rtl/pmem_responder_line_array.sv
// rtl/pmem_responder_line_array.sv - DEPTH x 128 line store, sync write, async read, sync clear
module pmem_line_array
    import pmem_responder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          we,
    input  logic [IDX_W-1:0] idx,
    input  lc3b_pmem_line wdata,
    output lc3b_pmem_line rdata
);

    lc3b_pmem_line mem [DEPTH];

    // Clear wipes every line and overrides any write in the same cycle.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/register.sv
// rtl/register.sv - generic load-enabled register with synchronous reset and flush
module register #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Hold value until load; reset or flush clears it.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - fixed-latency pmem line responder backed by an on-chip line store
module pmem_responder
    import pmem_responder_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 16
) (
    input  logic               clk,
    input  logic               reset,
    pmem_responder_if.slave    bus,
    output logic               busy,
    output logic               protocol_err,
    output logic [15:0]        rd_count,
    output logic [15:0]        wr_count
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    pmem_resp_state_t state, state_next;
    logic [3:0]       cnt;
    logic             op_write;
    logic             accept;
    logic             abort;
    logic             in_resp;
    logic             store_we;
    logic [IDX_W-1:0] idx_q;
    lc3b_pmem_line    wdata_q;
    lc3b_pmem_line    line_rdata;

    assign accept = (state == IDLE) && (bus.read || bus.write);
    assign abort  = !bus.read && !bus.write;

    // Only the line index is kept; offset and alias bits never matter after acceptance.
    register #(.WIDTH(IDX_W)) u_idx_reg (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .load  (accept),
        .d     (bus.address[PMEM_LINE_OFFSET +: IDX_W]),
        .q     (idx_q)
    );

    register #(.WIDTH(128)) u_wdata_reg (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .load  (accept),
        .d     (bus.wdata),
        .q     (wdata_q)
    );

    pmem_line_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lines (
        .clk   (clk),
        .clear (reset),
        .we    (store_we),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (line_rdata)
    );

    // State register plus the latency down-counter and latched op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_write <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt      <= CNT_LOAD;
                op_write <= bus.write;
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Next state: abort beats the final countdown step so a dropped request never responds.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.read || bus.write) begin
                    state_next = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (cnt == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: reset masks the response so a reset landing on RESP neither pulses nor commits.
    always_comb begin
        in_resp   = (state == RESP) && !reset;
        busy      = ((state == BUSY) || (state == RESP)) && !reset;
        bus.resp  = in_resp;
        store_we  = in_resp && op_write;
        bus.rdata = (in_resp && !op_write) ? line_rdata : '0;
    end

    // Sticky protocol error and saturating completion counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            protocol_err <= 1'b0;
            rd_count     <= '0;
            wr_count     <= '0;
        end else begin
            if (bus.read && bus.write) begin
                protocol_err <= 1'b1;
            end
            if (state == RESP) begin
                if (op_write) begin
                    wr_count <= sat_inc16(wr_count);
                end else begin
                    rd_count <= sat_inc16(rd_count);
                end
            end
        end
    end

endmodule
